gpr_wb_arbiter: RTL and testbench
=================================

GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, GPR index width (32 registers).
REQ-002 Parameter DATA_WIDTH, default 32, GPR data width.
REQ-003 Parameter NREQ, default 3, number of writeback requesters (0=ALU, 1=LSU, 2=CSR).
REQ-004 clk  input  1  clock; all state SHALL update on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester writeback request.
REQ-007 req_addr  input  NREQ*ADDR_WIDTH  destination register; slice i belongs to requester i.
REQ-008 req_data  input  NREQ*DATA_WIDTH  writeback data; slice i belongs to requester i.
REQ-009 req_ready  output  NREQ  grant; one-hot or zero.
REQ-010 iss_valid  input  1  issue stage announces a new producer of iss_rd.
REQ-011 iss_rd  input  ADDR_WIDTH  destination of the issuing instruction.
REQ-012 iss_ready  output  1  issue accepted.
REQ-013 rs1, rs2  input  ADDR_WIDTH each  source registers queried by decode.
REQ-014 rs1_busy, rs2_busy  output  1 each  source has a pending write.
REQ-015 gpr_wen, gpr_waddr, gpr_wdata  output  1/ADDR_WIDTH/DATA_WIDTH  register-file write port.

Function
REQ-016 Arbitration SHALL be round-robin over requesters with req_valid=1, starting at the pointer index and searching upward modulo NREQ.
REQ-017 req_ready[i] SHALL be combinational, high only for the single granted requester.
REQ-018 A handshake occurs when req_valid[i] and req_ready[i] are both high; requester i SHALL hold valid, addr and data stable until then.
REQ-019 After a handshake with requester i, the pointer SHALL become (i+1) mod NREQ; with no handshake it SHALL hold.
REQ-020 The write port SHALL be registered: a handshake in cycle N drives gpr_wen=1 with the granted addr/data during cycle N+1 only.
REQ-021 A handshake with addr 0 SHALL complete normally, advance the pointer, and leave gpr_wen=0 in cycle N+1.
REQ-022 At most one GPR write per cycle; with no handshake, gpr_wen SHALL be 0 in the next cycle.
REQ-023 The scoreboard SHALL hold one busy bit per register; bit 0 is constant 0.
REQ-024 iss_ready SHALL be 0 when iss_rd is nonzero and busy[iss_rd]=1 (WAW stall); otherwise 1.
REQ-025 An accepted issue with iss_rd nonzero SHALL set busy[iss_rd] at the clock edge.
REQ-026 busy[gpr_waddr] SHALL clear at the edge ending the cycle in which gpr_wen=1.
REQ-027 If a clear and a set target the same register in the same cycle, set SHALL win, and iss_ready SHALL be 1 in that cycle.
REQ-028 rsN_busy SHALL be combinational busy[rsN]; rsN=0 always returns 0.
REQ-029 Writebacks to a non-busy register SHALL be written without error; the scoreboard is unaffected apart from REQ-026.

Reset
REQ-030 On rst: all busy bits 0, pointer 0, gpr_wen 0, gpr_waddr 0, gpr_wdata 0.
REQ-031 During rst, req_ready and iss_ready SHALL be 0.
REQ-032 A handshake pending when rst asserts SHALL be discarded, with no write issued.

Structure
REQ-033 ADDR_WIDTH, DATA_WIDTH, NREQ defaults and requester index constants SHALL reside in shared package gpr_pkg.
REQ-034 The round-robin grant logic SHALL be a sub-module rr_arb, which takes a request vector and pointer and returns a one-hot grant.
REQ-035 Sequential logic SHALL use one synchronous-reset always block per state group: scoreboard, pointer, write-port register.

Verification
REQ-036 Issue rd=5, then ALU request addr=5, data=0xDEADBEEF -> handshake cycle N; cycle N+1 gpr_wen=1, waddr=5, wdata=0xDEADBEEF; rs1=5 gives busy=1 through N+1 and 0 at N+2.
REQ-037 All three requesters valid continuously from reset -> grants ALU, LSU, CSR, ALU in consecutive cycles.
REQ-038 LSU request to addr 0 -> handshake occurs and gpr_wen stays 0; pointer advances to 2.
REQ-039 busy[7]=1 with iss_rd=7 -> iss_ready=0; in the gpr_wen cycle for waddr=7 -> iss_ready=1, and busy[7] remains 1 afterwards.
REQ-040 rst asserted in the cycle of an ALU handshake -> gpr_wen=0 next cycle, all busy bits 0, and the next grant goes to ALU first.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared constants for the GPR writeback arbiter slice.
package gpr_pkg;

  localparam int unsigned GPR_ADDR_WIDTH = 5;
  localparam int unsigned GPR_DATA_WIDTH = 32;
  localparam int unsigned GPR_NREQ       = 3;

  // Requester indices on the writeback bus
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_CSR = 2;

  // Width of a pointer able to index n requesters (at least one bit)
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Writeback requests, issue handshake, operand busy query and GPR write port.
interface gpr_wb_arbiter_if
  import gpr_pkg::*;
#(
  parameter int unsigned NREQ       = GPR_NREQ,
  parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = GPR_DATA_WIDTH
) ();

  logic [NREQ-1:0]            req_valid;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_ready;

  logic                  iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic                  iss_ready;

  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;

  logic                  gpr_wen;
  logic [ADDR_WIDTH-1:0] gpr_waddr;
  logic [DATA_WIDTH-1:0] gpr_wdata;

  // Pipeline side: drives requests, issue and source queries
  modport master (
    output req_valid, req_addr, req_data, iss_valid, iss_rd, rs1, rs2,
    input  req_ready, iss_ready, rs1_busy, rs2_busy, gpr_wen, gpr_waddr, gpr_wdata
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_addr, req_data, iss_valid, iss_rd, rs1, rs2,
    output req_ready, iss_ready, rs1_busy, rs2_busy, gpr_wen, gpr_waddr, gpr_wdata
  );

endinterface

// File: rtl/gpr_wb_arbiter_rr_arb.sv
// Round-robin grant: first requester at or above ptr, wrapping modulo NREQ.
module rr_arb
  import gpr_pkg::*;
#(
  parameter int unsigned NREQ  = GPR_NREQ,
  parameter int unsigned PTR_W = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  int unsigned      idx;
  logic [PTR_W-1:0] sel;
  logic             found;

  // Search upward from the pointer and grant the first active request
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(ptr) + off) % NREQ;
      sel = PTR_W'(idx);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR writeback arbiter with register-busy scoreboard for issue WAW stalls.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = GPR_DATA_WIDTH,
  parameter int unsigned NREQ       = GPR_NREQ
) (
  input logic             clk,
  input logic             rst,
  gpr_wb_arbiter_if.slave bus
);

  localparam int unsigned NREG  = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W = ptr_width(NREQ);

  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_set;
  logic [NREG-1:0]       busy_clr;
  logic [PTR_W-1:0]      ptr;
  logic [NREQ-1:0]       gnt;
  logic                  hs;
  logic [PTR_W-1:0]      hs_idx;
  logic [ADDR_WIDTH-1:0] hs_addr;
  logic [DATA_WIDTH-1:0] hs_data;
  logic                  wr_hits_rd;
  logic                  iss_ok;

  rr_arb #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arb (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  // Grants are suppressed while in reset so no handshake can be taken
  assign bus.req_ready = rst ? '0 : gnt;

  // Select the address/data of the granted requester
  always_comb begin
    hs      = 1'b0;
    hs_idx  = '0;
    hs_addr = '0;
    hs_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (bus.req_ready[i]) begin
        hs      = 1'b1;
        hs_idx  = PTR_W'(i);
        hs_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        hs_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Issue acceptance and scoreboard set/clear vectors; a write retiring
  // the same register this cycle releases the WAW stall
  always_comb begin
    wr_hits_rd = bus.gpr_wen && (bus.gpr_waddr == bus.iss_rd);
    iss_ok     = !rst && !((bus.iss_rd != '0) && busy[bus.iss_rd] && !wr_hits_rd);
    busy_set   = '0;
    busy_clr   = '0;
    if (bus.iss_valid && iss_ok && (bus.iss_rd != '0)) begin
      busy_set[bus.iss_rd] = 1'b1;
    end
    if (bus.gpr_wen) begin
      busy_clr[bus.gpr_waddr] = 1'b1;
    end
  end

  assign bus.iss_ready = iss_ok;
  assign bus.rs1_busy  = busy[bus.rs1];
  assign bus.rs2_busy  = busy[bus.rs2];

  // Scoreboard: set beats clear, register 0 never busy
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~busy_clr) | busy_set) & ~NREG'(1);
    end
  end

  // Round-robin pointer moves past the requester just served
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (hs_idx == PTR_W'(NREQ - 1)) ? '0 : hs_idx + PTR_W'(1);
    end
  end

  // Registered GPR write port; writes to x0 are swallowed
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.gpr_wen   <= 1'b0;
      bus.gpr_waddr <= '0;
      bus.gpr_wdata <= '0;
    end else begin
      bus.gpr_wen <= hs && (hs_addr != '0);
      if (hs) begin
        bus.gpr_waddr <= hs_addr;
        bus.gpr_wdata <= hs_data;
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter with a queue-based grant/write scoreboard.
module tb_gpr_wb_arbiter;
  import gpr_pkg::*;

  localparam int unsigned AW = GPR_ADDR_WIDTH;
  localparam int unsigned DW = GPR_DATA_WIDTH;
  localparam int unsigned NR = GPR_NREQ;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  wr_t         wq[$];
  int unsigned gq[$];

  logic [AW-1:0] tb_addr [NR];
  logic [DW-1:0] tb_data [NR];

  always #5 clk = ~clk;

  gpr_wb_arbiter_if #(.NREQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  gpr_wb_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NREQ       (NR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_addr[i] = a;
    tb_data[i] = d;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  // Record the grant the current inputs must produce, and the write it implies
  task automatic expect_hs(input int unsigned i);
    wr_t w;
    gq.push_back(i);
    if (tb_addr[i] != '0) begin
      w.addr = tb_addr[i];
      w.data = tb_data[i];
      wq.push_back(w);
    end
  endtask

  // Monitor: compare every presented grant and every GPR write against the queues
  always @(negedge clk) begin
    wr_t           w;
    int unsigned   g;
    logic [NR-1:0] e;
    if (bus.gpr_wen === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", bus.gpr_wen, 0);
      end else begin
        w = wq.pop_front();
        chk("gpr_waddr", bus.gpr_waddr, w.addr);
        chk("gpr_wdata", bus.gpr_wdata, w.data);
      end
    end
    if (bus.req_ready !== '0) begin
      if (gq.size() == 0) begin
        chk("unexpected_grant", bus.req_ready, 0);
      end else begin
        g = gq.pop_front();
        e = NR'(1) << g;
        chk("grant", bus.req_ready, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned order [3] = '{REQ_LSU, REQ_CSR, REQ_ALU};

    // Reset with requests and an issue pending: nothing may be accepted
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    set_req(REQ_ALU, 5'd10, 32'hA000_0010);
    set_req(REQ_LSU, 5'd11, 32'hB000_0011);
    set_req(REQ_CSR, 5'd12, 32'hC000_0012);
    bus.req_valid = '1;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd3;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_iss_ready", bus.iss_ready, 0);
    chk("rst_gpr_wen", bus.gpr_wen, 0);
    chk("rst_gpr_waddr", bus.gpr_waddr, 0);
    chk("rst_gpr_wdata", bus.gpr_wdata, 0);
    next_cyc();
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.iss_valid = 1'b0;
    bus.rs1       = 5'd3;
    bus.rs2       = 5'd0;
    @(negedge clk);
    chk("rst_busy3_clear", bus.rs1_busy, 0);
    chk("rs2_x0_busy", bus.rs2_busy, 0);
    chk("idle_iss_ready", bus.iss_ready, 1);
    next_cyc();

    // Issue rd=5, then ALU writes 0xDEADBEEF to x5
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd5;
    @(negedge clk);
    chk("t36_iss_ready", bus.iss_ready, 1);
    next_cyc();
    bus.iss_valid = 1'b0;
    bus.rs1       = 5'd5;
    set_req(REQ_ALU, 5'd5, 32'hDEAD_BEEF);
    bus.req_valid = 3'b001;
    expect_hs(REQ_ALU);
    @(negedge clk);
    chk("t36_rs1_busy_n", bus.rs1_busy, 1);
    chk("t36_wen_n", bus.gpr_wen, 0);
    next_cyc();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t36_wen_n1", bus.gpr_wen, 1);
    chk("t36_rs1_busy_n1", bus.rs1_busy, 1);
    next_cyc();
    @(negedge clk);
    chk("t36_rs1_busy_n2", bus.rs1_busy, 0);
    chk("t36_wen_n2", bus.gpr_wen, 0);
    next_cyc();

    // LSU write to x0: handshake without a GPR write, pointer moves to CSR
    set_req(REQ_LSU, 5'd0, 32'h0000_1234);
    bus.req_valid = 3'b010;
    expect_hs(REQ_LSU);
    @(negedge clk);
    next_cyc();
    set_req(REQ_ALU, 5'd10, 32'hA000_0010);
    set_req(REQ_LSU, 5'd11, 32'hB000_0011);
    set_req(REQ_CSR, 5'd12, 32'hC000_0012);
    bus.req_valid = 3'b111;
    expect_hs(REQ_CSR);
    @(negedge clk);
    chk("t38_wen_x0", bus.gpr_wen, 0);
    next_cyc();
    bus.req_valid = '0;
    @(negedge clk);
    next_cyc();

    // Mark x9 busy and move the pointer to CSR, then reset over an ALU request
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd9;
    set_req(REQ_LSU, 5'd0, 32'h0000_5555);
    bus.req_valid = 3'b010;
    expect_hs(REQ_LSU);
    @(negedge clk);
    chk("t40_iss9_ready", bus.iss_ready, 1);
    next_cyc();
    rst           = 1'b1;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd3;
    set_req(REQ_ALU, 5'd9, 32'h0000_0099);
    bus.req_valid = 3'b001;
    @(negedge clk);
    chk("t40_rst_req_ready", bus.req_ready, 0);
    chk("t40_rst_iss_ready", bus.iss_ready, 0);
    next_cyc();

    // Out of reset with all requesters valid: ALU, LSU, CSR, ALU
    rst           = 1'b0;
    bus.iss_valid = 1'b0;
    bus.rs1       = 5'd9;
    bus.rs2       = 5'd3;
    set_req(REQ_ALU, 5'd10, 32'hA000_0010);
    bus.req_valid = 3'b111;
    expect_hs(REQ_ALU);
    @(negedge clk);
    chk("t40_wen_after_rst", bus.gpr_wen, 0);
    chk("t40_busy9_cleared", bus.rs1_busy, 0);
    chk("t40_busy3_clear", bus.rs2_busy, 0);
    foreach (order[k]) begin
      next_cyc();
      expect_hs(order[k]);
      @(negedge clk);
    end
    next_cyc();
    bus.req_valid = '0;
    @(negedge clk);
    next_cyc();

    // WAW stall on x7 released in the write cycle; the new issue keeps x7 busy
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd7;
    @(negedge clk);
    chk("t39_first_issue", bus.iss_ready, 1);
    next_cyc();
    set_req(REQ_CSR, 5'd7, 32'h0000_0077);
    bus.req_valid = 3'b100;
    expect_hs(REQ_CSR);
    @(negedge clk);
    chk("t39_waw_stall", bus.iss_ready, 0);
    next_cyc();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t39_wen", bus.gpr_wen, 1);
    chk("t39_iss_ready_on_clear", bus.iss_ready, 1);
    next_cyc();
    bus.iss_valid = 1'b0;
    bus.rs1       = 5'd7;
    bus.rs2       = 5'd0;
    @(negedge clk);
    chk("t39_busy7_kept", bus.rs1_busy, 1);
    chk("t39_rs2_x0", bus.rs2_busy, 0);
    chk("t39_stall_again", bus.iss_ready, 0);
    next_cyc();
    @(negedge clk);
    chk("t39_busy7_held", bus.rs1_busy, 1);
    chk("t39_idle_wen", bus.gpr_wen, 0);

    // Every expected grant and write must have been observed
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("writes_left", 64'(wq.size()), 0);
    chk("grants_left", 64'(gq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
